// File: rtl/p_i_cache_control.sv
// Instruction cache control FSM for a 4-way set-associative cache.
// Sequences array reads, hit responses, pseudo-LRU updates and line fills on a miss.
// The array mux select type is kept in a small package so the datapath can share it.

package p_i_cache_control_pkg;

    typedef enum logic [1:0] {
        no_write        = 2'b00,
        cpu_write_cache = 2'b01,
        mem_write_cache = 2'b10
    } dataarraymux_sel_t;

endpackage

module p_i_cache_control
    import p_i_cache_control_pkg::*;
#(
    parameter int num_ways  = 4,
    parameter int lru_width = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   mem_read,
    input  logic                   hit,
    input  logic                   way_0_hit,
    input  logic                   way_1_hit,
    input  logic                   way_2_hit,
    input  logic                   way_3_hit,
    input  logic                   v_array_0_dataout,
    input  logic                   v_array_1_dataout,
    input  logic                   v_array_2_dataout,
    input  logic                   v_array_3_dataout,
    input  logic [lru_width-1:0]   LRU_array_dataout,
    input  logic                   pmem_resp,

    output logic                   mem_resp,
    output logic                   addr_hold,
    output logic                   pmem_read,
    output logic                   read_array_flag,

    output logic                   v_array_0_load,
    output logic                   v_array_1_load,
    output logic                   v_array_2_load,
    output logic                   v_array_3_load,
    output logic                   v_array_0_datain,
    output logic                   v_array_1_datain,
    output logic                   v_array_2_datain,
    output logic                   v_array_3_datain,

    output logic                   tag_array_0_load,
    output logic                   tag_array_1_load,
    output logic                   tag_array_2_load,
    output logic                   tag_array_3_load,

    output logic                   LRU_array_load,
    output logic [lru_width-1:0]   LRU_array_datain,

    output dataarraymux_sel_t      write_en_0_MUX_sel,
    output dataarraymux_sel_t      write_en_1_MUX_sel,
    output dataarraymux_sel_t      write_en_2_MUX_sel,
    output dataarraymux_sel_t      write_en_3_MUX_sel,
    output dataarraymux_sel_t      data_array_0_datain_MUX_sel,
    output dataarraymux_sel_t      data_array_1_datain_MUX_sel,
    output dataarraymux_sel_t      data_array_2_datain_MUX_sel,
    output dataarraymux_sel_t      data_array_3_datain_MUX_sel
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        FILL   = 2'b01,
        REREAD = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic                   reqPending_q, reqPending_d;
    logic [1:0]             victim_q, victim_d;
    logic [lru_width-1:0]   savedLru_q, savedLru_d;

    logic [num_ways-1:0]    wayHitVec;
    logic [num_ways-1:0]    validVec;
    logic [1:0]             hitWay;
    logic [num_ways-1:0]    fillWays;

    assign wayHitVec = {way_3_hit, way_2_hit, way_1_hit, way_0_hit};
    assign validVec  = {v_array_3_dataout, v_array_2_dataout,
                        v_array_1_dataout, v_array_0_dataout};

    // Tree-PLRU update: mark the accessed way most recently used, leaving the
    // bit of the opposite subtree untouched.
    function automatic logic [lru_width-1:0] lruUpdate(
        input logic [lru_width-1:0] lru,
        input logic [1:0]           way
    );
        logic [lru_width-1:0] res;
        res = lru;
        case (way)
            2'd0: begin res[0] = 1'b1; res[1] = 1'b1; end
            2'd1: begin res[0] = 1'b1; res[1] = 1'b0; end
            2'd2: begin res[0] = 1'b0; res[2] = 1'b1; end
            default: begin res[0] = 1'b0; res[2] = 1'b0; end
        endcase
        return res;
    endfunction

    // Victim choice: any empty way (lowest index first), otherwise follow the
    // PLRU tree toward the least recently used leaf.
    function automatic logic [1:0] pickVictim(
        input logic [num_ways-1:0]  valid,
        input logic [lru_width-1:0] lru
    );
        logic [1:0] way;
        if (!valid[0])      way = 2'd0;
        else if (!valid[1]) way = 2'd1;
        else if (!valid[2]) way = 2'd2;
        else if (!valid[3]) way = 2'd3;
        else if (!lru[0])   way = lru[1] ? 2'd1 : 2'd0;
        else                way = lru[2] ? 2'd3 : 2'd2;
        return way;
    endfunction

    // Encode the hitting way; simultaneous hits are illegal, so the lowest
    // index simply wins for the LRU update.
    always_comb begin
        hitWay = 2'd0;
        if (wayHitVec[0])      hitWay = 2'd0;
        else if (wayHitVec[1]) hitWay = 2'd1;
        else if (wayHitVec[2]) hitWay = 2'd2;
        else if (wayHitVec[3]) hitWay = 2'd3;
    end

    // Output decode: everything idles at its default while reset is held so
    // no array write can slip through when reset lands on a fill response.
    always_comb begin
        mem_resp         = 1'b0;
        addr_hold        = 1'b0;
        pmem_read        = 1'b0;
        read_array_flag  = 1'b0;
        LRU_array_load   = 1'b0;
        LRU_array_datain = '0;
        fillWays         = '0;

        if (rst) begin
            case (state_q)
                RUN: begin
                    if (!reqPending_q) begin
                        read_array_flag = 1'b1;
                    end else if (hit) begin
                        mem_resp         = 1'b1;
                        read_array_flag  = 1'b1;
                        LRU_array_load   = 1'b1;
                        LRU_array_datain = lruUpdate(LRU_array_dataout, hitWay);
                    end else begin
                        addr_hold = 1'b1;
                    end
                end
                FILL: begin
                    pmem_read = 1'b1;
                    addr_hold = 1'b1;
                    if (pmem_resp) begin
                        fillWays         = num_ways'(1) << victim_q;
                        LRU_array_load   = 1'b1;
                        LRU_array_datain = lruUpdate(savedLru_q, victim_q);
                    end
                end
                REREAD: begin
                    read_array_flag = 1'b1;
                    addr_hold       = 1'b1;
                end
                default: begin
                    read_array_flag = 1'b0;
                end
            endcase
        end
    end

    // The filled way gets its tag, valid bit and data written from memory.
    assign tag_array_0_load = fillWays[0];
    assign tag_array_1_load = fillWays[1];
    assign tag_array_2_load = fillWays[2];
    assign tag_array_3_load = fillWays[3];

    assign v_array_0_load   = fillWays[0];
    assign v_array_1_load   = fillWays[1];
    assign v_array_2_load   = fillWays[2];
    assign v_array_3_load   = fillWays[3];

    assign v_array_0_datain = fillWays[0];
    assign v_array_1_datain = fillWays[1];
    assign v_array_2_datain = fillWays[2];
    assign v_array_3_datain = fillWays[3];

    assign write_en_0_MUX_sel = fillWays[0] ? mem_write_cache : no_write;
    assign write_en_1_MUX_sel = fillWays[1] ? mem_write_cache : no_write;
    assign write_en_2_MUX_sel = fillWays[2] ? mem_write_cache : no_write;
    assign write_en_3_MUX_sel = fillWays[3] ? mem_write_cache : no_write;

    assign data_array_0_datain_MUX_sel = fillWays[0] ? mem_write_cache : no_write;
    assign data_array_1_datain_MUX_sel = fillWays[1] ? mem_write_cache : no_write;
    assign data_array_2_datain_MUX_sel = fillWays[2] ? mem_write_cache : no_write;
    assign data_array_3_datain_MUX_sel = fillWays[3] ? mem_write_cache : no_write;

    // Next-state logic: a miss snapshots the victim and the LRU bits seen in
    // that cycle; the reread cycle re-arms the request so the next cycle hits.
    always_comb begin
        state_d      = state_q;
        reqPending_d = reqPending_q;
        victim_d     = victim_q;
        savedLru_d   = savedLru_q;

        if (read_array_flag) begin
            reqPending_d = mem_read;
        end

        case (state_q)
            RUN: begin
                if (reqPending_q && !hit) begin
                    state_d    = FILL;
                    victim_d   = pickVictim(validVec, LRU_array_dataout);
                    savedLru_d = LRU_array_dataout;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    state_d = REREAD;
                end
            end
            REREAD: begin
                state_d      = RUN;
                reqPending_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Controller state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RUN;
            reqPending_q <= 1'b0;
            victim_q     <= 2'd0;
            savedLru_q   <= '0;
        end else begin
            state_q      <= state_d;
            reqPending_q <= reqPending_d;
            victim_q     <= victim_d;
            savedLru_q   <= savedLru_d;
        end
    end

endmodule

// File: tb/tb_p_i_cache_control.sv
// Testbench for p_i_cache_control: directed scenarios followed by random traffic,
// every output compared each cycle against a behavioural model of the controller.

module tb_p_i_cache_control;
    import p_i_cache_control_pkg::*;

    logic clk;
    logic rst;
    logic memRead;
    logic hitIn;
    logic [3:0] wayHits;
    logic [3:0] valids;
    logic [2:0] lruIn;
    logic pmemResp;

    logic memResp, addrHold, pmemRead, readFlag;
    logic vLoad0, vLoad1, vLoad2, vLoad3;
    logic vData0, vData1, vData2, vData3;
    logic tagLoad0, tagLoad1, tagLoad2, tagLoad3;
    logic lruLoad;
    logic [2:0] lruData;
    dataarraymux_sel_t wrSel0, wrSel1, wrSel2, wrSel3;
    dataarraymux_sel_t dinSel0, dinSel1, dinSel2, dinSel3;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state, expressed as the outstanding-request bookkeeping
    bit         mPending;
    bit         mFilling;
    bit         mRereading;
    int         mVictim;
    logic [2:0] mLru;

    p_i_cache_control dut (
        .clk                         (clk),
        .rst                         (rst),
        .mem_read                    (memRead),
        .hit                         (hitIn),
        .way_0_hit                   (wayHits[0]),
        .way_1_hit                   (wayHits[1]),
        .way_2_hit                   (wayHits[2]),
        .way_3_hit                   (wayHits[3]),
        .v_array_0_dataout           (valids[0]),
        .v_array_1_dataout           (valids[1]),
        .v_array_2_dataout           (valids[2]),
        .v_array_3_dataout           (valids[3]),
        .LRU_array_dataout           (lruIn),
        .pmem_resp                   (pmemResp),
        .mem_resp                    (memResp),
        .addr_hold                   (addrHold),
        .pmem_read                   (pmemRead),
        .read_array_flag             (readFlag),
        .v_array_0_load              (vLoad0),
        .v_array_1_load              (vLoad1),
        .v_array_2_load              (vLoad2),
        .v_array_3_load              (vLoad3),
        .v_array_0_datain            (vData0),
        .v_array_1_datain            (vData1),
        .v_array_2_datain            (vData2),
        .v_array_3_datain            (vData3),
        .tag_array_0_load            (tagLoad0),
        .tag_array_1_load            (tagLoad1),
        .tag_array_2_load            (tagLoad2),
        .tag_array_3_load            (tagLoad3),
        .LRU_array_load              (lruLoad),
        .LRU_array_datain            (lruData),
        .write_en_0_MUX_sel          (wrSel0),
        .write_en_1_MUX_sel          (wrSel1),
        .write_en_2_MUX_sel          (wrSel2),
        .write_en_3_MUX_sel          (wrSel3),
        .data_array_0_datain_MUX_sel (dinSel0),
        .data_array_1_datain_MUX_sel (dinSel1),
        .data_array_2_datain_MUX_sel (dinSel2),
        .data_array_3_datain_MUX_sel (dinSel3)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the model's expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: observed 'h%0h, expected 'h%0h", tag, $time, observed, expected);
        end
    endtask

    // PLRU update written arithmetically: way w sets the root to "go the other
    // half" and its leaf bit to "go the other leaf".
    function automatic logic [2:0] modelUpd(input logic [2:0] l, input int w);
        logic [2:0] r;
        r = l;
        r[0] = (w < 2);
        if (w < 2) r[1] = (w == 0);
        else       r[2] = (w == 2);
        return r;
    endfunction

    function automatic int modelVictim(input logic [3:0] v, input logic [2:0] l);
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) return i;
        end
        return 2 * int'(l[0]) + (l[0] ? int'(l[2]) : int'(l[1]));
    endfunction

    function automatic int lowestHit(input logic [3:0] wh);
        for (int i = 0; i < 4; i++) begin
            if (wh[i]) return i;
        end
        return 0;
    endfunction

    // Drive one cycle of inputs, check all outputs, then advance the model at the edge
    task automatic applyStimulus(input bit r, input bit mr, input logic [3:0] wh,
                                 input logic [3:0] v, input logic [2:0] l, input bit pr);
        bit         eMemResp, ePmemRead, eAddrHold, eReadFlag, eLruLoad;
        logic [2:0] eLruData;
        logic [3:0] eFill;
        logic [7:0] eSel;
        logic [7:0] oWr, oDin;

        rst      = r;
        memRead  = mr;
        wayHits  = wh;
        hitIn    = |wh;
        valids   = v;
        lruIn    = l;
        pmemResp = pr;
        #2;

        eMemResp = 0; ePmemRead = 0; eAddrHold = 0; eReadFlag = 0; eLruLoad = 0;
        eLruData = 3'b000;
        eFill    = 4'b0000;
        if (r) begin
            if (mFilling) begin
                ePmemRead = 1;
                eAddrHold = 1;
                if (pr) begin
                    eFill    = 4'b0001 << mVictim;
                    eLruLoad = 1;
                    eLruData = modelUpd(mLru, mVictim);
                end
            end else if (mRereading) begin
                eReadFlag = 1;
                eAddrHold = 1;
            end else if (!mPending) begin
                eReadFlag = 1;
            end else if (|wh) begin
                eMemResp  = 1;
                eReadFlag = 1;
                eLruLoad  = 1;
                eLruData  = modelUpd(l, lowestHit(wh));
            end else begin
                eAddrHold = 1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            eSel[2*k +: 2] = eFill[k] ? mem_write_cache : no_write;
        end
        oWr  = {wrSel3, wrSel2, wrSel1, wrSel0};
        oDin = {dinSel3, dinSel2, dinSel1, dinSel0};

        checkOutput("memResp",  32'(memResp),  32'(eMemResp));
        checkOutput("pmemRead", 32'(pmemRead), 32'(ePmemRead));
        checkOutput("addrHold", 32'(addrHold), 32'(eAddrHold));
        checkOutput("readFlag", 32'(readFlag), 32'(eReadFlag));
        checkOutput("lruLoad",  32'(lruLoad),  32'(eLruLoad));
        checkOutput("lruData",  32'(lruData),  32'(eLruData));
        checkOutput("tagLoad",  32'({tagLoad3, tagLoad2, tagLoad1, tagLoad0}), 32'(eFill));
        checkOutput("vLoad",    32'({vLoad3, vLoad2, vLoad1, vLoad0}), 32'(eFill));
        checkOutput("vData",    32'({vData3, vData2, vData1, vData0}), 32'(eFill));
        checkOutput("wrSel",    32'(oWr),  32'(eSel));
        checkOutput("dinSel",   32'(oDin), 32'(eSel));

        @(posedge clk);
        if (!r) begin
            mPending   = 0;
            mFilling   = 0;
            mRereading = 0;
            mVictim    = 0;
        end else if (mFilling) begin
            if (pr) begin
                mFilling   = 0;
                mRereading = 1;
            end
        end else if (mRereading) begin
            mRereading = 0;
            mPending   = 1;
        end else if (mPending && !(|wh)) begin
            mFilling = 1;
            mVictim  = modelVictim(v, l);
            mLru     = l;
        end else begin
            mPending = mr;
        end
        #1;
    endtask

    // Request, miss, a few wait cycles, fill response, reread, then the hit on the victim
    task automatic missAndFill(input logic [3:0] v, input logic [2:0] l, input int waitCycles);
        int victim;
        victim = modelVictim(v, l);
        applyStimulus(1, 1, 4'b0000, v, l, 0);
        applyStimulus(1, 1, 4'b0000, v, l, 0);
        for (int i = 0; i < waitCycles; i++) applyStimulus(1, 0, 4'b0000, v, l, 0);
        applyStimulus(1, 0, 4'b0000, v, l, 1);
        applyStimulus(1, 0, 4'b0000, v, l, 0);
        applyStimulus(1, 0, 4'b0001 << victim, v | (4'b0001 << victim), l, 0);
    endtask

    initial begin
        logic [3:0] wh;
        logic [3:0] v;
        mPending = 0; mFilling = 0; mRereading = 0; mVictim = 0; mLru = 3'b000;

        // Reset held with noisy inputs, including a fill response
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'b0000, 4'b0000, 3'b000, 1);

        // Cold miss into an empty set: way0 victim, LRU written as 3'b011
        missAndFill(4'b0000, 3'b000, 5);

        // Hit streaming on way1
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 4'b0010, 4'b0011, 3'b100, 0);
        applyStimulus(1, 0, 4'b0010, 4'b0011, 3'b100, 0);

        // Full-set eviction picks way3 from LRU 3'b101
        applyStimulus(1, 0, 4'b0000, 4'b1111, 3'b101, 0);
        missAndFill(4'b1111, 3'b101, 2);

        // Invalid way beats PLRU choice
        applyStimulus(1, 0, 4'b0000, 4'b1011, 3'b000, 0);
        missAndFill(4'b1011, 3'b000, 1);

        // Reset lands on the fill response
        applyStimulus(1, 0, 4'b0000, 4'b1111, 3'b010, 0);
        applyStimulus(1, 1, 4'b0000, 4'b1111, 3'b010, 0);
        applyStimulus(1, 1, 4'b0000, 4'b1111, 3'b010, 0);
        applyStimulus(1, 0, 4'b0000, 4'b1111, 3'b010, 0);
        applyStimulus(0, 0, 4'b0000, 4'b1111, 3'b010, 1);
        applyStimulus(1, 0, 4'b0000, 4'b1111, 3'b010, 0);

        // Stray fill responses while idle
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 4'b0000, 4'b1111, 3'b000, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            wh = 4'b0000;
            if ($urandom_range(0, 1) == 1) begin
                wh = 4'b0001 << $urandom_range(0, 3);
                if ($urandom_range(0, 9) == 0) wh = wh | (4'b0001 << $urandom_range(0, 3));
            end
            v = 4'($urandom);
            if ($urandom_range(0, 9) < 4) v = 4'b1111;
            applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, wh, v,
                          3'($urandom), $urandom_range(0, 9) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
